// File: rtl/spi_adc_pkg.sv
// spi_adc_pkg: shared state encoding and frame-format constants for the SPI ADC link
package spi_adc_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_LEAD_ZEROS = 4;
  localparam int DEF_FRAME_BITS = DEF_DATA_W + DEF_LEAD_ZEROS;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int MIN_CS_SETUP_CLKS = DEF_SYNC_STAGES + 2;
endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: N-stage input synchronizer with rise/fall pulses decoded from flops only
module spi_in_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  // synchronizer chain plus a one-cycle-delayed copy of its last stage for edge detection
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync_q <= {STAGES{INIT}};
      dly_q  <= INIT;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~dly_q;
  assign fall_o = ~sync_o & dly_q;
endmodule

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI mode-0 responder emulating a 12-bit ADC frame source
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int  DATA_W      = DEF_DATA_W,
  parameter int  LEAD_ZEROS  = DEF_LEAD_ZEROS,
  parameter int  SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int FRAME_BITS  = DATA_W + LEAD_ZEROS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     sample_data,
  input  logic                  sample_valid,
  input  logic                  SCK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT = CW'(FRAME_BITS + 1);

  logic sck_sync, sck_rise, sck_fall, cs_sync, cs_rise, cs_fall, mosi_s;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES:0]   settle_q, settle_d;
  logic                   armed_q, armed_d;
  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic [FRAME_BITS-1:0]  tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   miso_q, miso_d, oe_q, oe_d, rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;

  spi_in_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck_sync (
    .clk(clk), .reset(reset), .d_i(SCK), .sync_o(sck_sync), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .d_i(CS), .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // state and datapath registers; reset aborts any frame without a status pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mosi_q      <= '0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      hold_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end

  // next state; a CS fall is only trusted once the synchronized bus has been seen idle
  // (CS high, SCK low) after reset, so a CS held low through reset is ignored
  always_comb begin
    settle_d    = {settle_q[SYNC_STAGES-1:0], 1'b1};
    armed_d     = armed_q | (settle_q[SYNC_STAGES] & cs_sync & ~sck_sync);
    state_d     = state_q;
    hold_d      = sample_valid ? sample_data : hold_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: state_d = (armed_q && cs_fall) ? LOAD : IDLE;
      LOAD: begin
        tx_d    = {{LEAD_ZEROS{1'b0}}, hold_q};
        miso_d  = tx_d[FRAME_BITS-1];
        oe_d    = 1'b1;
        cnt_d   = '0;
        rx_d    = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (sck_rise) begin
          rx_d  = {rx_q[FRAME_BITS-2:0], mosi_s};
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
        if (sck_fall) begin
          tx_d   = tx_q << 1;
          miso_d = (cnt_q >= CNT_FULL) ? 1'b0 : tx_d[FRAME_BITS-1];
        end
        state_d = cs_rise ? DONE : SHIFT;
      end
      DONE: begin
        rx_valid_d  = (cnt_q == CNT_FULL);
        frame_err_d = (cnt_q != CNT_FULL);
        rx_data_d   = (cnt_q == CNT_FULL) ? rx_q : rx_data_q;
        miso_d      = 1'b0;
        oe_d        = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO      = miso_q;
  assign miso_oe   = oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == LOAD) || (state_q == SHIFT);
endmodule
